// File: rtl/hwag_coil_scheduler_if.sv
// Bus bundle for the HWAG coil scheduler: angle input, config port and coil/spark/fault outputs.
// The master side (angle generator / CPU) drives inputs; the slave side is the scheduler.
interface hwag_coil_scheduler_if #(
  parameter int CHANNELS   = 4,
  parameter int ACNT_WIDTH = 24
);
  logic                  hwag_start;
  logic [ACNT_WIDTH-1:0] acnt_in;
  logic                  acnt_tick;
  logic                  cfg_we;
  logic [2:0]            cfg_ch;
  logic [1:0]            cfg_field;
  logic [ACNT_WIDTH-1:0] cfg_data;
  logic                  cfg_err;
  logic [CHANNELS-1:0]   coil_out;
  logic [CHANNELS-1:0]   spark_out;
  logic [CHANNELS-1:0]   fault_out;

  modport master (
    output hwag_start, acnt_in, acnt_tick, cfg_we, cfg_ch, cfg_field, cfg_data,
    input  cfg_err, coil_out, spark_out, fault_out
  );

  modport slave (
    input  hwag_start, acnt_in, acnt_tick, cfg_we, cfg_ch, cfg_field, cfg_data,
    output cfg_err, coil_out, spark_out, fault_out
  );
endinterface

// File: rtl/hwag_coil_scheduler.sv
// N-channel ignition coil scheduler: per-channel phase/set/reset angles with staged commit at spark,
// per-channel enable and a max-dwell guard that latches a sticky fault.
module hwag_coil_scheduler #(
  parameter int                     CHANNELS    = 4,
  parameter int                     ACNT_WIDTH  = 24,
  parameter int                     ANGLE_MAX   = 3839,
  parameter int                     DWELL_WIDTH = 20,
  parameter logic [DWELL_WIDTH-1:0] MAX_DWELL   = 20'd800000
) (
  input  logic                   clk,
  input  logic                   rst,
  hwag_coil_scheduler_if.slave   bus
);

  localparam int AW = ACNT_WIDTH;
  localparam logic [AW:0]          L_MAX   = (AW+1)'(ANGLE_MAX);
  localparam logic [AW:0]          L_MOD   = L_MAX + (AW+1)'(1);
  localparam logic [DWELL_WIDTH-1:0] DW_SAT = '1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SET, S_DWELL, S_FAULT} state_t;

  state_t              r_state [CHANNELS];
  state_t              w_next  [CHANNELS];
  logic [AW-1:0]       r_phase [CHANNELS];
  logic [AW-1:0]       r_set   [CHANNELS];
  logic [AW-1:0]       r_rang  [CHANNELS];
  logic [AW-1:0]       r_stg_phase [CHANNELS];
  logic [AW-1:0]       r_stg_set   [CHANNELS];
  logic [AW-1:0]       r_stg_rang  [CHANNELS];
  logic [DWELL_WIDTH-1:0] r_dwell  [CHANNELS];
  logic [DWELL_WIDTH-1:0] w_dwell_inc [CHANNELS];
  logic [AW:0]         w_sum   [CHANNELS];
  logic [AW-1:0]       w_loc   [CHANNELS];

  logic [CHANNELS-1:0] r_en, r_fault, r_coil, r_spark;
  logic [CHANNELS-1:0] w_spark, w_commit, w_ctrl_wr, w_stg_wr, w_clr;
  logic                r_cfg_err;
  logic                w_ch_ok, w_ang_ok, w_cfg_bad, w_wr_ok;

  assign w_ch_ok   = (int'(bus.cfg_ch) < CHANNELS);
  assign w_ang_ok  = (bus.cfg_data <= AW'(ANGLE_MAX));
  assign w_cfg_bad = bus.cfg_we & (~w_ch_ok | ((bus.cfg_field != 2'd3) & ~w_ang_ok));
  assign w_wr_ok   = bus.cfg_we & ~w_cfg_bad;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      w_sum[ch] = {1'b0, bus.acnt_in} + {1'b0, r_phase[ch]};
      if (w_sum[ch] > L_MAX) w_sum[ch] = w_sum[ch] - L_MOD;
      w_loc[ch]       = w_sum[ch][AW-1:0];
      w_dwell_inc[ch] = (r_dwell[ch] == DW_SAT) ? r_dwell[ch] : r_dwell[ch] + 1'b1;
      w_ctrl_wr[ch]   = w_wr_ok & (bus.cfg_field == 2'd3) & (bus.cfg_ch == 3'(ch));
      w_stg_wr[ch]    = w_wr_ok & (bus.cfg_field != 2'd3) & (bus.cfg_ch == 3'(ch));
      w_clr[ch]       = w_ctrl_wr[ch] & bus.cfg_data[1];
    end
  end

  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      w_next[ch]   = r_state[ch];
      w_spark[ch]  = 1'b0;
      w_commit[ch] = 1'b0;
      case (r_state[ch])
        S_IDLE: begin
          w_commit[ch] = 1'b1;
          if (bus.hwag_start && r_en[ch]) w_next[ch] = S_WAIT_SET;
        end
        S_WAIT_SET: begin
          w_commit[ch] = ~bus.hwag_start;
          if (!(bus.hwag_start && r_en[ch]))
            w_next[ch] = S_IDLE;
          else if (bus.acnt_tick && (w_loc[ch] == r_set[ch]) && (r_set[ch] != r_rang[ch]))
            w_next[ch] = S_DWELL;
        end
        S_DWELL: begin
          if (!(bus.hwag_start && r_en[ch])) begin
            w_next[ch] = S_IDLE;
          end else if (bus.acnt_tick && (w_loc[ch] == r_rang[ch])) begin
            w_next[ch]   = S_WAIT_SET;
            w_spark[ch]  = 1'b1;
            w_commit[ch] = 1'b1;
          end else if (w_dwell_inc[ch] == MAX_DWELL) begin
            w_next[ch] = S_FAULT;
          end
        end
        S_FAULT: begin
          if (w_clr[ch]) w_next[ch] = S_IDLE;
        end
        default: w_next[ch] = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_err <= 1'b0;
      r_en      <= '0;
      r_fault   <= '0;
      r_coil    <= '0;
      r_spark   <= '0;
      // NOTE: the angle register arrays are reset explicitly; a cleared config is part of the reset state.
      for (int ch = 0; ch < CHANNELS; ch++) begin
        r_state[ch]     <= S_IDLE;
        r_phase[ch]     <= '0;
        r_set[ch]       <= '0;
        r_rang[ch]      <= '0;
        r_stg_phase[ch] <= '0;
        r_stg_set[ch]   <= '0;
        r_stg_rang[ch]  <= '0;
        r_dwell[ch]     <= '0;
      end
    end else begin
      r_cfg_err <= w_cfg_bad;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        r_state[ch] <= w_next[ch];
        r_coil[ch]  <= (w_next[ch] == S_DWELL);
        r_spark[ch] <= w_spark[ch];
        r_dwell[ch] <= (r_state[ch] == S_DWELL) ? w_dwell_inc[ch] : '0;

        if ((r_state[ch] == S_DWELL) && (w_next[ch] == S_FAULT)) r_fault[ch] <= 1'b1;
        else if (w_clr[ch])                                      r_fault[ch] <= 1'b0;

        if (w_ctrl_wr[ch]) r_en[ch] <= bus.cfg_data[0];

        // Commit reads the pre-edge staging value, so a same-cycle write waits for the next commit.
        if (w_commit[ch]) begin
          r_phase[ch] <= r_stg_phase[ch];
          r_set[ch]   <= r_stg_set[ch];
          r_rang[ch]  <= r_stg_rang[ch];
        end

        if (w_stg_wr[ch]) begin
          case (bus.cfg_field)
            2'd0:    r_stg_phase[ch] <= bus.cfg_data;
            2'd1:    r_stg_set[ch]   <= bus.cfg_data;
            default: r_stg_rang[ch]  <= bus.cfg_data;
          endcase
        end
      end
    end
  end

  assign bus.cfg_err   = r_cfg_err;
  assign bus.coil_out  = r_coil;
  assign bus.spark_out = r_spark;
  assign bus.fault_out = r_fault;

endmodule

// File: tb/tb_hwag_coil_scheduler.sv
// Directed bench for hwag_coil_scheduler: angle sweeps with hand-derived dwell windows,
// staged commits, max-dwell fault, config rejection and hwag_start/reset drop-outs.
module tb_hwag_coil_scheduler;

  localparam int CH = 4;
  localparam int AW = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hwag_coil_scheduler_if #(.CHANNELS(CH), .ACNT_WIDTH(AW)) bus ();

  hwag_coil_scheduler #(
    .CHANNELS(CH), .ACNT_WIDTH(AW), .ANGLE_MAX(3839), .DWELL_WIDTH(20), .MAX_DWELL(20'd1500)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic tick(input int a);
    bus.acnt_in   = AW'(a);
    bus.acnt_tick = 1'b1;
    @(negedge clk);
    bus.acnt_tick = 1'b0;
  endtask

  task automatic cfg(input int ch, input int field, input int data);
    bus.cfg_we    = 1'b1;
    bus.cfg_ch    = 3'(ch);
    bus.cfg_field = 2'(field);
    bus.cfg_data  = AW'(data);
    @(negedge clk);
    bus.cfg_we    = 1'b0;
  endtask

  // Channel c must be high after ticks in [s, e) and spark exactly at tick e; s = e = -1 means never.
  task automatic run(input string tag, input int from, input int to,
                     input int s0, input int e0, input int s1, input int e1);
    int bad = 0;
    int sp0 = 0;
    int sp1 = 0;
    for (int a = from; a <= to; a++) begin
      tick(a);
      if (bus.coil_out[0] !== ((a >= s0) && (a < e0))) bad++;
      if (bus.coil_out[1] !== ((a >= s1) && (a < e1))) bad++;
      if (bus.coil_out[3:2] !== 2'b00) bad++;
      if (bus.spark_out[0]) begin sp0++; if (a != e0) bad++; end
      if (bus.spark_out[1]) begin sp1++; if (a != e1) bad++; end
      if (bus.spark_out[3:2] !== 2'b00) bad++;
    end
    check({tag, "_coil"}, bad, 0);
    check({tag, "_spark0"}, sp0, ((s0 >= 0) && (e0 >= from) && (e0 <= to)) ? 1 : 0);
    check({tag, "_spark1"}, sp1, ((s1 >= 0) && (e1 >= from) && (e1 <= to)) ? 1 : 0);
  endtask

  initial begin
    int m;
    int sp;
    bus.hwag_start = 1'b0;
    bus.acnt_in    = '0;
    bus.acnt_tick  = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.cfg_ch     = '0;
    bus.cfg_field  = '0;
    bus.cfg_data   = '0;
    rst = 1'b1;
    repeat (3) cyc();
    check("rst_coil",  bus.coil_out,  0);
    check("rst_spark", bus.spark_out, 0);
    check("rst_fault", bus.fault_out, 0);
    check("rst_err",   bus.cfg_err,   0);
    rst = 1'b0;
    bus.hwag_start = 1'b1;
    cyc();

    // 1: ch0 dwells 3000..3839
    cfg(0, 0, 0); cfg(0, 1, 3000); cfg(0, 2, 3839); cfg(0, 3, 1);
    check("cfg_ok_err", bus.cfg_err, 0);
    cyc();
    run("t1", 0, 3839, 3000, 3839, -1, -1);
    cyc();
    check("t1_spark_pulse_end", bus.spark_out, 0);

    // 2: ch1 phase 1920 dwells 1080..1919
    cfg(1, 0, 1920); cfg(1, 1, 3000); cfg(1, 2, 3839); cfg(1, 3, 1);
    cyc();
    run("t2", 0, 3839, 3000, 3839, 1080, 1919);

    // 3: staged set write mid-dwell takes effect only after this spark
    run("t3a", 0, 3200, 3000, 3839, 1080, 1919);
    cfg(0, 1, 2500);
    check("t3_wr_err", bus.cfg_err, 0);
    check("t3_coil_held", bus.coil_out[0], 1);
    run("t3b", 3201, 3839, 3000, 3839, 1080, 1919);
    run("t3c", 0, 3839, 2500, 3839, 1080, 1919);

    // 4: ticks stop mid-dwell; dwell entered at tick 2500, coil high 1500 clk in total
    run("t4a", 0, 2600, 2500, 3839, 1080, 1919);
    m = 0;
    sp = 0;
    while ((bus.coil_out[0] === 1'b1) && (m < 3000)) begin
      cyc();
      m++;
      if (bus.spark_out[0]) sp++;
    end
    check("t4_dwell_len", m, 1400);
    check("t4_no_spark", sp, 0);
    check("t4_fault", bus.fault_out, 4'b0001);
    cfg(0, 3, 3);
    check("t4_fault_clr", bus.fault_out, 0);
    run("t4b", 0, 3839, 2500, 3839, 1080, 1919);

    // 5: rejected writes, then set==reset on ch1
    cfg(0, 1, 3840);
    check("t5_err_range", bus.cfg_err, 1);
    cyc();
    check("t5_err_pulse", bus.cfg_err, 0);
    cfg(5, 1, 100);
    check("t5_err_ch", bus.cfg_err, 1);
    cfg(1, 3, 0);
    cyc();
    cfg(1, 1, 3839);
    cfg(1, 3, 1);
    cyc();
    run("t5", 0, 3839, 2500, 3839, -1, -1);

    // 6: hwag_start drop mid-dwell; staged set commits while low
    run("t6a", 0, 2700, 2500, 3839, -1, -1);
    cfg(0, 1, 2400);
    check("t6_coil_held", bus.coil_out[0], 1);
    bus.hwag_start = 1'b0;
    cyc();
    check("t6_coil_off", bus.coil_out, 0);
    check("t6_no_spark", bus.spark_out, 0);
    cyc();
    bus.hwag_start = 1'b1;
    cyc();
    run("t6b", 0, 3839, 2400, 3839, -1, -1);

    // reset mid-dwell
    run("t7a", 0, 2500, 2400, 3839, -1, -1);
    rst = 1'b1;
    cyc();
    check("t7_coil_off", bus.coil_out, 0);
    check("t7_no_spark", bus.spark_out, 0);
    check("t7_fault", bus.fault_out, 0);
    rst = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
